// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters, with the starvation
// counter that forces a fetch grant after STARVE_LIMIT consecutive losses.
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic arb_en,
  output logic grant_if
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  assign grant_if = if_req && (!d_req || (starve_q >= LIMIT));

  // Only arbitrations where fetch is actually asking move the counter.
  always_comb begin
    starve_d = starve_q;
    if (arb_en && if_req) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (starve_q != '1) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port main memory (fetch vs. data).
// Define MEM_ARB_PERF_CNT_EN to add grant and contention counters.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [15:0]       if_grant_cnt,
  output logic [15:0]       d_grant_cnt,
  output logic [15:0]       contention_cnt
`endif
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
  logic              grant_if;
  logic              arb_en;

  assign arb_en = (state_q == IDLE);

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .d_req   (d_req),
    .arb_en  (arb_en),
    .grant_if(grant_if)
  );

  // mem_rdata is valid MEM_LATENCY cycles after the mem_en cycle, which is
  // the WAIT cycle in which the latency counter has run down to zero.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d  = WAIT;
          mem_en_d = 1'b1;
          cnt_d    = LAT;
          if (grant_if) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end else begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] if_grant_cnt_q, if_grant_cnt_d;
  logic [15:0] d_grant_cnt_q, d_grant_cnt_d;
  logic [15:0] contention_cnt_q, contention_cnt_d;

  // Every IDLE cycle with a request is a grant; counters wrap freely.
  always_comb begin
    if_grant_cnt_d   = if_grant_cnt_q;
    d_grant_cnt_d    = d_grant_cnt_q;
    contention_cnt_d = contention_cnt_q;
    if (arb_en && (if_req || d_req)) begin
      if (grant_if) begin
        if_grant_cnt_d = if_grant_cnt_q + 16'd1;
      end else begin
        d_grant_cnt_d = d_grant_cnt_q + 16'd1;
      end
    end
    if (arb_en && if_req && d_req) begin
      contention_cnt_d = contention_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_grant_cnt_q   <= '0;
      d_grant_cnt_q    <= '0;
      contention_cnt_q <= '0;
    end else begin
      if_grant_cnt_q   <= if_grant_cnt_d;
      d_grant_cnt_q    <= d_grant_cnt_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign if_grant_cnt   = if_grant_cnt_q;
  assign d_grant_cnt    = d_grant_cnt_q;
  assign contention_cnt = contention_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int LAT   = 2;
  localparam int LIMIT = 3;
  localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;
  localparam logic [31:0] IF_A    = 32'h0000_0100;
  localparam logic [31:0] D_A     = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = GARBAGE;
  logic        busy;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] if_grant_cnt;
  logic [15:0] d_grant_cnt;
  logic [15:0] contention_cnt;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0] mem_arr [0:255];
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = '0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_CNT_EN
    , .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt),
    .contention_cnt(contention_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory answers only in the cycle exactly LAT after the mem_en cycle.
  always @(negedge clk) begin
    mem_rdata = GARBAGE;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) mem_rdata = mem_arr[pend_addr[9:2]];
    end
    if (mem_en) begin
      pend_cnt  = LAT;
      pend_addr = mem_addr;
      if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic waitDone(input bit is_if, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (is_if ? if_done : d_done) begin
        lat = i;
        break;
      end
    end
  endtask

  // Returns 1 for a fetch grant, 0 for a data grant, -1 if no mem_en arrives.
  task automatic waitGrant(output int gnt);
    gnt = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_en) begin
        gnt = (mem_addr == IF_A) ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic runStarve();
    int gnt;
    int lat;
    applyStimulus(1'b1, IF_A, 1'b1, 1'b0, D_A, 32'h0);
    for (int k = 0; k < 8; k++) begin
      waitGrant(gnt);
      checkOutput($sformatf("starve grant %0d is IF", k), 32'(gnt), ((k % 4) == 3) ? 32'd1 : 32'd0);
    end
    waitDone(1'b1, lat);
    checkOutput("starve last if_done latency", 32'(lat), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int gnt;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h1000_0000 + i;
    mem_arr[8'h10] = 32'hDEAD_BEEF;
    mem_arr[8'h04] = 32'hCAFE_F00D;
    mem_arr[8'h08] = 32'h0BAD_CAFE;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset if_done", 32'(if_done), 32'd0);
    checkOutput("reset d_done", 32'(d_done), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset if_rdata", if_rdata, 32'h0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    rst = 1'b1;

    // Reset while a fetch read is in WAIT.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("abort pre mem_en", 32'(mem_en), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort mem_en", 32'(mem_en), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort if_done", 32'(if_done), 32'd0);
    checkOutput("abort mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    waitDone(1'b1, lat);
    checkOutput("reissue latency", 32'(lat), 32'd4);
    checkOutput("reissue if_rdata", if_rdata, 32'h0BAD_CAFE);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("reissue idle busy", 32'(busy), 32'd0);

    // Fetch read with cycle-by-cycle timing.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("if c1 mem_en", 32'(mem_en), 32'd1);
    checkOutput("if c1 mem_addr", mem_addr, 32'h40);
    checkOutput("if c1 mem_we", 32'(mem_we), 32'd0);
    checkOutput("if c1 busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("if c2 mem_en", 32'(mem_en), 32'd0);
    checkOutput("if c2 mem_addr", mem_addr, 32'h40);
    checkOutput("if c2 busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("if c3 if_done", 32'(if_done), 32'd0);
    checkOutput("if c3 busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("if c4 if_done", 32'(if_done), 32'd1);
    checkOutput("if c4 if_rdata", if_rdata, 32'hDEAD_BEEF);
    checkOutput("if c4 busy", 32'(busy), 32'd1);
    checkOutput("if c4 d_done", 32'(d_done), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("if c5 if_done", 32'(if_done), 32'd0);
    checkOutput("if c5 busy", 32'(busy), 32'd0);
    checkOutput("if c5 mem_addr", mem_addr, 32'h0);

    // Data read, then data write that must leave d_rdata alone.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    waitDone(1'b0, lat);
    checkOutput("d read latency", 32'(lat), 32'd4);
    checkOutput("d read d_rdata", d_rdata, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234_5678);
    @(negedge clk);
    checkOutput("wr c1 mem_en", 32'(mem_en), 32'd1);
    checkOutput("wr c1 mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr c1 mem_addr", mem_addr, 32'h80);
    checkOutput("wr c1 mem_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    checkOutput("wr c2 mem_en", 32'(mem_en), 32'd0);
    checkOutput("wr c2 mem_addr", mem_addr, 32'h80);
    checkOutput("wr c2 mem_wdata", mem_wdata, 32'h1234_5678);
    waitDone(1'b0, lat);
    checkOutput("wr done latency", 32'(lat), 32'd2);
    checkOutput("wr d_rdata kept", d_rdata, 32'hCAFE_F00D);
    checkOutput("wr done mem_wdata", mem_wdata, 32'h1234_5678);
    checkOutput("wr memory content", mem_arr[8'h20], 32'h1234_5678);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Simultaneous requests: data first, fetch next.
    applyStimulus(1'b1, IF_A, 1'b1, 1'b0, D_A, 32'h0);
    waitGrant(gnt);
    checkOutput("both first grant IF", 32'(gnt), 32'd0);
    waitDone(1'b0, lat);
    checkOutput("both d latency", 32'(lat), 32'd3);
    checkOutput("both d_rdata", d_rdata, 32'h1000_0080);
    applyStimulus(1'b1, IF_A, 1'b0, 1'b0, 32'h0, 32'h0);
    waitGrant(gnt);
    checkOutput("both second grant IF", 32'(gnt), 32'd1);
    waitDone(1'b1, lat);
    checkOutput("both if latency", 32'(lat), 32'd3);
    checkOutput("both if_rdata", if_rdata, 32'h1000_0040);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Starvation pattern relies on the counter being clear after the fetch grant above.
    runStarve();

`ifdef MEM_ARB_PERF_CNT_EN
    doReset();
    checkOutput("perf reset if_grant_cnt", 32'(if_grant_cnt), 32'd0);
    runStarve();
    checkOutput("perf d_grant_cnt", 32'(d_grant_cnt), 32'd6);
    checkOutput("perf if_grant_cnt", 32'(if_grant_cnt), 32'd2);
    checkOutput("perf contention_cnt", 32'(contention_cnt), 32'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
